// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand width, result-entry width and opcode encoding.
// The result FIFO and its interface import this for their defaults.
package alu_pkg;

    localparam int BITS        = 4;
    localparam int ALU_ENTRY_W = BITS + 3;

    typedef enum logic [2:0] {
        OPC_ADD  = 3'b000,
        OPC_SUB  = 3'b001,
        OPC_AND  = 3'b010,
        OPC_OR   = 3'b011,
        OPC_XOR  = 3'b100,
        OPC_NOT  = 3'b101,
        OPC_INV0 = 3'b110,
        OPC_INV1 = 3'b111
    } alu_opc_e;

    // Opcodes the ALU flags with Invalid.
    function automatic logic is_invalid_opc(input alu_opc_e opc);
        return (opc == OPC_INV0) || (opc == OPC_INV1);
    endfunction

    // Width of one stored entry {invalid, parity, out[bits:0]}.
    function automatic int entry_width(input int bits);
        return bits + 3;
    endfunction

endpackage

// File: rtl/alu_result_fifo_if.sv
// Producer and consumer handshake bundle around the ALU result FIFO.
// The FIFO connects through the slave modport; the environment drives the master side.
interface alu_result_fifo_if
    import alu_pkg::*;
#(
    parameter int BITS = alu_pkg::BITS
);

    logic            in_valid;
    logic            in_ready;
    logic [BITS:0]   alu_out;
    logic            alu_parity;
    logic            alu_invalid;

    logic            out_valid;
    logic            out_ready;
    logic [BITS:0]   out_data;
    logic            out_parity;
    logic            out_invalid;

    modport master (
        output in_valid, alu_out, alu_parity, alu_invalid, out_ready,
        input  in_ready, out_valid, out_data, out_parity, out_invalid
    );

    modport slave (
        input  in_valid, alu_out, alu_parity, alu_invalid, out_ready,
        output in_ready, out_valid, out_data, out_parity, out_invalid
    );

endinterface

// File: rtl/alu_res_fifo_mem.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
// Storage is cleared by reset so the head reads zero straight out of reset.
module alu_res_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 7,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    // NOTE: the next-state copy starts from the current contents so every
    // entry is assigned on every path; without that default this infers latches.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // NOTE: this array is small and visible at the head output, so it is reset
    // like ordinary flops; a large RAM macro would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Capture stage behind the ALU: DEPTH-entry result FIFO with valid/ready on both
// sides and a saturating count of accepted invalid-opcode results.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int BITS         = alu_pkg::BITS,
    parameter int DEPTH        = 4,
    parameter int CNT_W        = 8,
    parameter int DROP_INVALID = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_result_fifo_if.slave         io,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         invalid_cnt
);

    localparam int   AW      = $clog2(DEPTH);
    localparam int   CW      = AW + 1;
    localparam int   ENTRY_W = entry_width(BITS);
    localparam logic DROP    = (DROP_INVALID != 0);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [CNT_W-1:0] invalid_cnt_q, invalid_cnt_d;

    logic full, empty;
    logic accept, push, pop;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;

    // Ready/valid depend on occupancy only, so a full FIFO never accepts while popping.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign io.in_ready  = !full;
    assign io.out_valid = !empty;

    assign accept = io.in_valid & !full;
    assign push   = accept & !(DROP & io.alu_invalid);
    assign pop    = !empty & io.out_ready;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        invalid_cnt_d = invalid_cnt_q;

        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Dropped invalid results are still counted; the counter sticks at all-ones.
        if (accept && io.alu_invalid && (invalid_cnt_q != '1)) begin
            invalid_cnt_d = invalid_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            invalid_cnt_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            invalid_cnt_q <= invalid_cnt_d;
        end
    end

    assign wr_entry = {io.alu_invalid, io.alu_parity, io.alu_out};

    alu_res_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // Show-ahead head: the entry at rd_ptr is presented without waiting for a pop.
    assign io.out_invalid = rd_entry[ENTRY_W-1];
    assign io.out_parity  = rd_entry[ENTRY_W-2];
    assign io.out_data    = rd_entry[BITS:0];

    assign count       = count_q;
    assign invalid_cnt = invalid_cnt_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: three configurations (default, DROP_INVALID=1, CNT_W=2)
// share one stimulus stream and are each scored against a queue-based model.
module tb_alu_result_fifo;

    localparam int B = 4;
    localparam int D = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid    = 1'b0;
    logic [B:0]   alu_out     = '0;
    logic         alu_parity  = 1'b0;
    logic         alu_invalid = 1'b0;
    logic         out_ready   = 1'b0;

    alu_result_fifo_if #(.BITS(B)) if0 ();
    alu_result_fifo_if #(.BITS(B)) if1 ();
    alu_result_fifo_if #(.BITS(B)) if2 ();

    assign if0.in_valid = in_valid;  assign if0.alu_out = alu_out;
    assign if0.alu_parity = alu_parity;  assign if0.alu_invalid = alu_invalid;
    assign if0.out_ready = out_ready;
    assign if1.in_valid = in_valid;  assign if1.alu_out = alu_out;
    assign if1.alu_parity = alu_parity;  assign if1.alu_invalid = alu_invalid;
    assign if1.out_ready = out_ready;
    assign if2.in_valid = in_valid;  assign if2.alu_out = alu_out;
    assign if2.alu_parity = alu_parity;  assign if2.alu_invalid = alu_invalid;
    assign if2.out_ready = out_ready;

    logic [2:0] cnt0, cnt1, cnt2;
    logic [7:0] icnt0, icnt1;
    logic [1:0] icnt2;

    alu_result_fifo #(.BITS(B), .DEPTH(D), .CNT_W(8), .DROP_INVALID(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .io(if0), .count(cnt0), .invalid_cnt(icnt0));
    alu_result_fifo #(.BITS(B), .DEPTH(D), .CNT_W(8), .DROP_INVALID(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .io(if1), .count(cnt1), .invalid_cnt(icnt1));
    alu_result_fifo #(.BITS(B), .DEPTH(D), .CNT_W(2), .DROP_INVALID(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .io(if2), .count(cnt2), .invalid_cnt(icnt2));

    // Observed outputs gathered per configuration.
    logic [6:0] o_head [3];
    logic [2:0] o_cnt  [3];
    logic [7:0] o_icnt [3];
    logic       o_ov   [3];
    logic       o_ir   [3];

    assign o_head[0] = {if0.out_invalid, if0.out_parity, if0.out_data};
    assign o_head[1] = {if1.out_invalid, if1.out_parity, if1.out_data};
    assign o_head[2] = {if2.out_invalid, if2.out_parity, if2.out_data};
    assign o_cnt[0] = cnt0;  assign o_cnt[1] = cnt1;  assign o_cnt[2] = cnt2;
    assign o_icnt[0] = icnt0; assign o_icnt[1] = icnt1; assign o_icnt[2] = {6'b0, icnt2};
    assign o_ov[0] = if0.out_valid; assign o_ov[1] = if1.out_valid; assign o_ov[2] = if2.out_valid;
    assign o_ir[0] = if0.in_ready;  assign o_ir[1] = if1.in_ready;  assign o_ir[2] = if2.in_ready;

    // Reference model: a queue of {invalid, parity, data} per configuration.
    logic [6:0] mq [3][$];
    int         m_icnt [3];
    int         m_drop [3] = '{0, 1, 0};
    int         m_max  [3] = '{255, 255, 3};

    int total = 0;
    int bad   = 0;

    // Drives one cycle of inputs, scores all three DUTs against the model before
    // the edge, then advances the model. Entered and left on a falling edge.
    task automatic step(input logic v, input logic [B:0] d, input logic p,
                        input logic inv, input logic ordy);
        in_valid = v; alu_out = d; alu_parity = p; alu_invalid = inv; out_ready = ordy;
        #1;
        for (int k = 0; k < 3; k++) begin
            int sz;
            sz = mq[k].size();
            total++;
            if (o_cnt[k] !== 3'(sz)) begin
                bad++; $display("FAIL step count dut%0d: got %0d want %0d", k, o_cnt[k], sz);
            end
            total++;
            if (o_ov[k] !== (sz != 0)) begin
                bad++; $display("FAIL step out_valid dut%0d: got %0b want %0b", k, o_ov[k], sz != 0);
            end
            total++;
            if (o_ir[k] !== (sz < D)) begin
                bad++; $display("FAIL step in_ready dut%0d: got %0b want %0b", k, o_ir[k], sz < D);
            end
            total++;
            if (o_icnt[k] !== 8'(m_icnt[k])) begin
                bad++; $display("FAIL step invalid_cnt dut%0d: got %0d want %0d", k, o_icnt[k], m_icnt[k]);
            end
            if (sz > 0) begin
                total++;
                if (o_head[k] !== mq[k][0]) begin
                    bad++; $display("FAIL step head dut%0d: got %h want %h", k, o_head[k], mq[k][0]);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            logic acc, pp;
            acc = v && (mq[k].size() < D);
            pp  = ordy && (mq[k].size() > 0);
            if (acc && inv && m_icnt[k] < m_max[k]) m_icnt[k]++;
            if (pp) void'(mq[k].pop_front());
            if (acc && !(m_drop[k] != 0 && inv)) mq[k].push_back({inv, p, d});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        if (cnt0 !== 3'd0)      begin bad++; $display("FAIL reset count: got %0d want 0", cnt0); end
        if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %0b want 0", if0.out_valid); end
        if (if0.in_ready !== 1'b1)  begin bad++; $display("FAIL reset in_ready: got %0b want 1", if0.in_ready); end
        if (icnt0 !== 8'd0)     begin bad++; $display("FAIL reset invalid_cnt: got %0d want 0", icnt0); end
        if (o_head[0] !== 7'd0) begin bad++; $display("FAIL reset head: got %h want 00", o_head[0]); end
        total += 5;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), ^5'(i), 1'b0, 1'b0);
        total += 2;
        if (cnt0 !== 3'd4)         begin bad++; $display("FAIL fill count: got %0d want 4", cnt0); end
        if (if0.in_ready !== 1'b0) begin bad++; $display("FAIL fill in_ready: got %0b want 0", if0.in_ready); end
        step(1'b1, 5'h05, 1'b0, 1'b0, 1'b0);
        total++;
        if (cnt0 !== 3'd4) begin bad++; $display("FAIL overflow count: got %0d want 4", cnt0); end
        for (int i = 1; i <= 4; i++) begin
            #1;
            total++;
            if (if0.out_data !== 5'(i)) begin
                bad++; $display("FAIL drain order: got %h want %h", if0.out_data, 5'(i));
            end
            step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        end
        total++;
        if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL drain empty: got %0b want 0", if0.out_valid); end
    endtask

    task automatic test_push_pop();
        step(1'b1, 5'h10, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'h11, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            #1;
            total++;
            if (if0.out_data !== 5'(16 + i)) begin
                bad++; $display("FAIL push_pop order: got %h want %h", if0.out_data, 5'(16 + i));
            end
            step(1'b1, 5'(18 + i), ^5'(18 + i), 1'b0, 1'b1);
            total++;
            if (cnt0 !== 3'd2) begin bad++; $display("FAIL push_pop count: got %0d want 2", cnt0); end
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_invalid();
        step(1'b1, 5'h1F, 1'b1, 1'b1, 1'b0);
        total += 6;
        if (o_head[0] !== 7'h7F) begin bad++; $display("FAIL invalid head: got %h want 7f", o_head[0]); end
        if (icnt0 !== 8'd1)      begin bad++; $display("FAIL invalid cnt keep: got %0d want 1", icnt0); end
        if (cnt0 !== 3'd1)       begin bad++; $display("FAIL invalid count keep: got %0d want 1", cnt0); end
        if (cnt1 !== 3'd0)       begin bad++; $display("FAIL drop count: got %0d want 0", cnt1); end
        if (if1.in_ready !== 1'b1) begin bad++; $display("FAIL drop in_ready: got %0b want 1", if1.in_ready); end
        if (icnt1 !== 8'd1)      begin bad++; $display("FAIL drop invalid_cnt: got %0d want 1", icnt1); end
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) step(1'b1, 5'($urandom_range(31)), 1'b0, 1'b1, 1'b1);
        total += 2;
        if (icnt2 !== 2'd3) begin bad++; $display("FAIL saturate: got %0d want 3", icnt2); end
        if (icnt0 !== 8'd6) begin bad++; $display("FAIL wide invalid_cnt: got %0d want 6", icnt0); end
        step(1'b1, 5'h07, 1'b1, 1'b1, 1'b1);
        total++;
        if (icnt2 !== 2'd3) begin bad++; $display("FAIL saturate hold: got %0d want 3", icnt2); end
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, 5'(3 + i), 1'b0, 1'b0, 1'b0);
        total++;
        if (cnt0 !== 3'd3) begin bad++; $display("FAIL mid precount: got %0d want 3", cnt0); end
        in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total += 4;
            if (o_cnt[k] !== 3'd0) begin bad++; $display("FAIL async count dut%0d: got %0d want 0", k, o_cnt[k]); end
            if (o_ov[k] !== 1'b0)  begin bad++; $display("FAIL async out_valid dut%0d: got %0b want 0", k, o_ov[k]); end
            if (o_ir[k] !== 1'b1)  begin bad++; $display("FAIL async in_ready dut%0d: got %0b want 1", k, o_ir[k]); end
            if (o_icnt[k] !== 8'd0) begin bad++; $display("FAIL async invalid_cnt dut%0d: got %0d want 0", k, o_icnt[k]); end
            mq[k].delete();
            m_icnt[k] = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 5'h0A, 1'b0, 1'b0, 1'b0);
        total += 2;
        if (if0.out_data !== 5'h0A) begin bad++; $display("FAIL post-reset head: got %h want 0a", if0.out_data); end
        if (cnt0 !== 3'd1)          begin bad++; $display("FAIL post-reset count: got %0d want 1", cnt0); end
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [B:0] d;
            d = 5'($urandom_range(31));
            step(($urandom_range(3) != 0), d, ^d, ($urandom_range(4) == 0), ($urandom_range(2) != 0));
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_push_pop();
        test_invalid();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
